mips_reg_file: RTL and testbench

- General-purpose register file for the pipelined MIPS core, directly downstream of the destination-register select mux.
- Consumes the 5-bit write-register address chosen there (rt or rd), carried through the pipeline to write-back.
- Provides two combinational read ports to decode, with write-to-read bypass.
- Provides a registered debug read port and a one-cycle write-trace strobe for the debug unit.

---
 rtl/mips_reg_file.sv | 55 +++++
 tb/tb_mips_reg_file.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_file.sv
// mips_reg_file: MIPS general-purpose register file with write-to-read bypass,
// a registered debug read port and a one-cycle write-trace strobe.
module mips_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              dbg_rd,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_valid,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [N];
    logic              wr_eff;
    logic [DATA_W-1:0] dbg_byp;

    // r0 is never written, so it stays at its reset value of zero
    assign wr_eff    = rst_n && wr_en && (wr_addr != '0);
    assign rd_data_a = (wr_eff && rd_addr_a == wr_addr) ? wr_data : mem[rd_addr_a];
    assign rd_data_b = (wr_eff && rd_addr_b == wr_addr) ? wr_data : mem[rd_addr_b];
    assign dbg_byp   = (wr_eff && dbg_addr == wr_addr) ? wr_data : mem[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            dbg_data    <= '0;
            dbg_valid   <= 1'b0;
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            if (wr_eff) begin
                mem[wr_addr] <= wr_data;
                trace_addr   <= wr_addr;
                trace_data   <= wr_data;
            end
            if (dbg_rd) dbg_data <= dbg_byp;
            dbg_valid   <= dbg_rd;
            trace_valid <= wr_eff;
        end
    end
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: directed stimulus against an array-based register model,
// checked every cycle plus literal expectations for the key scenarios.
module tb_mips_reg_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, dbg_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0, dbg_rd = 1'b0;
    logic [31:0] rd_data_a, rd_data_b, dbg_data, trace_data;
    logic        dbg_valid, trace_valid;
    logic [4:0]  trace_addr;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [31:0] m [32] = '{default: 32'h0};
    logic [31:0] e_dbg_data = '0, e_trace_data = '0;
    logic        e_dbg_valid = 1'b0, e_trace_valid = 1'b0;
    logic [4:0]  e_trace_addr = '0;

    mips_reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_rd(dbg_rd),
        .dbg_data(dbg_data), .dbg_valid(dbg_valid),
        .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data)
    );

    always #5 clk = ~clk;

    // value a reader must see: the in-flight write if it targets a, else storage
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rst_n && wr_en && wr_addr == a) return wr_data;
        return m[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m[i]) m[i] <= 32'h0;
            e_dbg_data    <= '0;
            e_dbg_valid   <= 1'b0;
            e_trace_valid <= 1'b0;
            e_trace_addr  <= '0;
            e_trace_data  <= '0;
        end else begin
            if (dbg_rd) e_dbg_data <= exp_rd(dbg_addr);
            e_dbg_valid   <= dbg_rd;
            e_trace_valid <= wr_en && wr_addr != 0;
            if (wr_en && wr_addr != 0) begin
                m[wr_addr]   <= wr_data;
                e_trace_addr <= wr_addr;
                e_trace_data <= wr_data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_rd_a", rd_data_a, exp_rd(rd_addr_a));
            chk("cyc_rd_b", rd_data_b, exp_rd(rd_addr_b));
            chk("cyc_dbg_valid", {31'b0, dbg_valid}, {31'b0, e_dbg_valid});
            chk("cyc_dbg_data", dbg_data, e_dbg_data);
            chk("cyc_trace_valid", {31'b0, trace_valid}, {31'b0, e_trace_valid});
            chk("cyc_trace_addr", {27'b0, trace_addr}, {27'b0, e_trace_addr});
            chk("cyc_trace_data", trace_data, e_trace_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();
        check_en = 1'b1;
        chk("reset_rd_a", rd_data_a, 32'h0);
        chk("reset_dbg_valid", {31'b0, dbg_valid}, 32'h0);

        // basic write/read with trace
        wr(5'd9, 32'hDEADBEEF);
        rd_addr_a = 5'd9;
        #1;
        chk("basic_rd_a", rd_data_a, 32'hDEADBEEF);
        chk("basic_trace_valid", {31'b0, trace_valid}, 32'h1);
        chk("basic_trace_addr", {27'b0, trace_addr}, 32'd9);
        chk("basic_trace_data", trace_data, 32'hDEADBEEF);
        tick();
        chk("basic_trace_drop", {31'b0, trace_valid}, 32'h0);
        chk("basic_trace_hold", trace_data, 32'hDEADBEEF);

        // bypass on both ports
        wr(5'd5, 32'h11);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h22;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        chk("bypass_a", rd_data_a, 32'h22);
        chk("bypass_b", rd_data_b, 32'h22);
        tick();
        wr_en = 1'b0;
        #1;
        chk("bypass_stored", rd_data_a, 32'h22);

        // r0 protection
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd0;
        #1;
        chk("r0_no_bypass", rd_data_a, 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_stays_zero", rd_data_a, 32'h0);
        chk("r0_no_trace", {31'b0, trace_valid}, 32'h0);

        // debug reads with a write to the same register in the second cycle
        wr(5'd31, 32'h1234);
        dbg_rd = 1'b1; dbg_addr = 5'd31;
        tick();
        chk("dbg_first", dbg_data, 32'h1234);
        chk("dbg_valid_1", {31'b0, dbg_valid}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h5678;
        tick();
        wr_en = 1'b0;
        chk("dbg_second", dbg_data, 32'h5678);
        chk("dbg_valid_2", {31'b0, dbg_valid}, 32'h1);
        dbg_rd = 1'b0;
        tick();
        chk("dbg_valid_low", {31'b0, dbg_valid}, 32'h0);
        chk("dbg_hold", dbg_data, 32'h5678);

        // asynchronous reset mid-run with strobes active
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; dbg_rd = 1'b1; dbg_addr = 5'd9;
        tick();
        wr_en = 1'b0; dbg_rd = 1'b0;
        chk("pre_reset_trace", {31'b0, trace_valid}, 32'h1);
        chk("pre_reset_dbg", {31'b0, dbg_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_dbg_valid", {31'b0, dbg_valid}, 32'h0);
        chk("async_trace_valid", {31'b0, trace_valid}, 32'h0);
        chk("async_dbg_data", dbg_data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            #1;
            chk("reset_clear_a", rd_data_a, 32'h0);
            chk("reset_clear_b", rd_data_b, 32'h0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // sweep all registers
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        for (int i = 1; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(32 - i);
            #1;
            chk("sweep_a", rd_data_a, 32'(i) * 32'h01010101);
            chk("sweep_b", rd_data_b, 32'(32 - i) * 32'h01010101);
        end
        dbg_rd = 1'b1;
        for (int i = 1; i < 32; i++) begin
            dbg_addr = 5'(i);
            tick();
            chk("sweep_dbg", dbg_data, 32'(i) * 32'h01010101);
            chk("sweep_dbg_valid", {31'b0, dbg_valid}, 32'h1);
        end
        dbg_rd = 1'b0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
